me_fullsearch: RTL and testbench
================================

Name: me_fullsearch

Overview:
- Parametrised full-search integer motion-estimation engine; next generation of the 4x4 ME top.
- Scans every candidate in a ±SEARCH_RANGE window around one BLK_DIM x BLK_DIM current block and returns the minimum-SAD motion vector.
- New features:
  - Partial-SAD early abort per candidate.
  - Optional threshold-based search termination.
  - Valid/ready handshakes on both block input and result.
- Sits between the current-frame block buffer / search-window RAM and the mode-decision stage.

Parameters:
- BLK_DIM, 4: block edge in pixels; power of two, 4..16.
- SEARCH_RANGE, 8: max |mv| per axis; window edge W = BLK_DIM + 2*SEARCH_RANGE.
- PIX_W, 8: pixel width.
- Derived widths:
  - CW = $clog2(W)
  - MVW = $clog2(SEARCH_RANGE+1)+1, signed
  - SW = PIX_W + 2*$clog2(BLK_DIM)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cur_valid  in  1  current-block row valid
- cur_ready  out  1  engine accepts a current-block row
- cur_row  in  BLK_DIM*PIX_W  one block row; pixel 0 in LSBs
- early_term_en  in  1  enable threshold termination; sampled with last row
- sad_thresh  in  SW  termination threshold; sampled with last row
- ref_rd_en  out  1  window read strobe
- ref_rd_x  out  CW  window column of leftmost pixel
- ref_rd_y  out  CW  window row
- ref_rd_data  in  BLK_DIM*PIX_W  window pixels [y][x..x+BLK_DIM-1]; valid exactly 1 cycle after ref_rd_en
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- mv_x  out  MVW  signed horizontal MV
- mv_y  out  MVW  signed vertical MV
- min_sad  out  SW  SAD of chosen MV
- cand_cnt  out  16  candidates started in this search

Behaviour:
- Reset (async, active-high): state LOAD, all counters 0, best_sad = all ones.
  - Outputs while rst high: cur_ready=0, ref_rd_en=0, res_valid=0, mv_x=mv_y=0, min_sad=0, cand_cnt=0.
  - cur_ready=1 from the first clk edge after rst deasserts.
  - Reset mid-search discards all state; no partial result is ever presented.
- LOAD:
  - cur_ready=1; each cur_valid&&cur_ready stores cur_row into row counter index 0..BLK_DIM-1.
  - On the last row: sample early_term_en/sad_thresh, best_sad=all ones, cand=(-R,-R), go to SEARCH.
- SEARCH:
  - cur_ready=0.
  - Candidate (dx,dy) maps to window origin (dx+R, dy+R).
  - One row read per cycle: ref_rd_x=dx+R, ref_rd_y=dy+R+r, for r=0..BLK_DIM-1.
  - Return cycle: acc += Σ|cur[r][i]−ref[i]|. Unsigned abs diff, zero-extended to SW; no saturation needed.
  - Early abort: if (acc including current row) >= best_sad, the candidate is dropped.
    - The one in-flight read is discarded.
    - Row 0 of the next candidate is issued in the same cycle.
  - Completion: last row returns and acc < best_sad, so best := (acc, dx, dy).
    - Ties keep the earlier candidate (raster order: dx fastest, then dy).
  - cand_cnt increments when row 0 of each candidate is issued.
  - Termination when either:
    - the last candidate (+R,+R) completes or aborts, or
    - early_term_en && a completed candidate's SAD <= sad_thresh.
  - On termination: ref_rd_en=0 the next cycle, go to DONE.
  - The first candidate can never abort, since best_sad starts at all ones.
  - Without any aborts, SEARCH lasts (2R+1)^2*BLK_DIM + 1 cycles.
- DONE:
  - res_valid=1; mv_x, mv_y, min_sad, cand_cnt stable until res_valid&&res_ready.
  - On that handshake: res_valid=0 next cycle, state LOAD, cur_ready=1 next cycle.
  - res_ready asserted while res_valid=0 is ignored.
- Result registers are held through LOAD and SEARCH until the next DONE. Reset is the only clear.
- Simultaneous events: cur_valid is ignored outside LOAD. A handshake and entry to LOAD in the same cycle is not possible; LOAD begins the cycle after.

Test Plan:
- Flat match, BLK_DIM=4, R=8: cur all 10, window all 10, early_term_en=0 -> mv=(-8,-8), min_sad=0, cand_cnt=289. Every candidate after the first aborts at row 0.
- Unique match: window pseudo-random, cur block copied to window origin (11,5), early_term_en=0 -> mv=(3,-3), min_sad=0, cand_cnt=289.
- Threshold stop: same data as the unique-match case, early_term_en=1, sad_thresh=0 -> mv=(3,-3), min_sad=0, cand_cnt=97. No ref_rd_en after the last row of candidate 96.
- Max SAD: cur all 255, window all 0 -> min_sad=4080, mv=(-8,-8). Verify no wrap with SW=12.
- Backpressure: hold res_ready=0 for 20 cycles in DONE -> res_valid, mv, min_sad stable; cur_ready=0. One-cycle res_ready -> res_valid=0 and cur_ready=1 next cycle.
- Reset mid-SEARCH: pulse rst for 1 cycle at the 50th SEARCH cycle -> outputs at reset values during the pulse. A subsequently loaded unique-match block returns mv=(3,-3), min_sad=0.

Source files
------------

// File: rtl/me_fullsearch.sv
`default_nettype none
// ============================================================================
// Module   : me_fullsearch
// Purpose  : Full-search integer motion estimation with early abort and
//            threshold termination; valid/ready on block input and result.
// Revision : 1.0 - initial release
// ============================================================================
module me_fullsearch #(
    parameter int BLK_DIM      = 4,
    parameter int SEARCH_RANGE = 8,
    parameter int PIX_W        = 8,
    parameter int CW           = $clog2(BLK_DIM + 2*SEARCH_RANGE),
    parameter int MVW          = $clog2(SEARCH_RANGE+1) + 1,
    parameter int SW           = PIX_W + 2*$clog2(BLK_DIM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cur_valid,
    output logic                     cur_ready,
    input  logic [BLK_DIM*PIX_W-1:0] cur_row,
    input  logic                     early_term_en,
    input  logic [SW-1:0]            sad_thresh,
    output logic                     ref_rd_en,
    output logic [CW-1:0]            ref_rd_x,
    output logic [CW-1:0]            ref_rd_y,
    input  logic [BLK_DIM*PIX_W-1:0] ref_rd_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [MVW-1:0]    mv_x,
    output logic signed [MVW-1:0]    mv_y,
    output logic [SW-1:0]            min_sad,
    output logic [15:0]              cand_cnt
);

    localparam int              RW         = $clog2(BLK_DIM);
    localparam logic [CW-1:0]   c_LAST     = CW'(2*SEARCH_RANGE);
    localparam logic [RW-1:0]   c_ROW_LAST = RW'(BLK_DIM-1);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic                     r_live;
    logic [BLK_DIM*PIX_W-1:0] r_cur [BLK_DIM];
    logic [RW-1:0]            r_load_row;
    logic                     r_et_en;
    logic [SW-1:0]            r_thresh;
    logic [CW-1:0]            r_px, r_py;
    logic [RW-1:0]            r_prow;
    logic                     r_all_issued;
    logic                     r_ret_valid;
    logic [CW-1:0]            r_ret_x, r_ret_y;
    logic [RW-1:0]            r_ret_row;
    logic [SW-1:0]            r_acc, r_best_sad;
    logic [CW-1:0]            r_best_x, r_best_y;
    logic [15:0]              r_cand_cnt;

    logic                     w_accept, w_load_last;
    logic [BLK_DIM*PIX_W-1:0] w_cur_sel;
    logic [PIX_W-1:0]         w_ad [BLK_DIM];
    logic [SW-1:0]            w_row_sad, w_acc_new;
    logic                     w_ret_search, w_drop, w_complete, w_term;
    logic [CW-1:0]            w_nx, w_ny;
    logic                     w_iss_en;
    logic [CW-1:0]            w_iss_x, w_iss_y;
    logic [RW-1:0]            w_iss_row;
    logic [CW-1:0]            w_best_x_nxt, w_best_y_nxt;
    logic [SW-1:0]            w_best_sad_nxt;

    assign cur_ready   = (r_state == S_LOAD) && r_live;
    assign w_accept    = cur_valid && cur_ready;
    assign w_load_last = w_accept && (r_load_row == c_ROW_LAST);

    assign w_cur_sel = r_cur[r_ret_row];

    for (genvar i = 0; i < BLK_DIM; i++) begin : g_absdiff
        logic [PIX_W-1:0] w_a, w_b;
        assign w_a    = w_cur_sel[i*PIX_W +: PIX_W];
        assign w_b    = ref_rd_data[i*PIX_W +: PIX_W];
        assign w_ad[i] = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
    end

    always_comb begin
        w_row_sad = '0;
        for (int i = 0; i < BLK_DIM; i++) begin
            w_row_sad = w_row_sad + SW'(w_ad[i]);
        end
    end

    assign w_acc_new    = (r_ret_row == '0) ? w_row_sad : (r_acc + w_row_sad);
    assign w_ret_search = (r_state == S_SEARCH) && r_ret_valid;
    assign w_drop       = w_ret_search && (w_acc_new >= r_best_sad);
    assign w_complete   = w_ret_search && (r_ret_row == c_ROW_LAST) && !w_drop;
    assign w_term       = ((w_drop || w_complete) && (r_ret_x == c_LAST) && (r_ret_y == c_LAST))
                        || (w_complete && r_et_en && (w_acc_new <= r_thresh));

    // Successor of the candidate whose data is returning, in raster order
    assign w_nx = (r_ret_x == c_LAST) ? '0 : (r_ret_x + CW'(1));
    assign w_ny = (r_ret_x == c_LAST) ? (r_ret_y + CW'(1)) : r_ret_y;

    always_comb begin
        w_iss_en  = 1'b0;
        w_iss_x   = r_px;
        w_iss_y   = r_py;
        w_iss_row = r_prow;
        if ((r_state == S_SEARCH) && !w_term) begin
            if (w_drop) begin
                w_iss_en  = 1'b1;
                w_iss_x   = w_nx;
                w_iss_y   = w_ny;
                w_iss_row = '0;
            end else if (!r_all_issued) begin
                w_iss_en = 1'b1;
            end
        end
    end

    assign ref_rd_en = w_iss_en;
    assign ref_rd_x  = w_iss_x;
    assign ref_rd_y  = w_iss_y + CW'(w_iss_row);

    assign w_best_x_nxt   = w_complete ? r_ret_x   : r_best_x;
    assign w_best_y_nxt   = w_complete ? r_ret_y   : r_best_y;
    assign w_best_sad_nxt = w_complete ? w_acc_new : r_best_sad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_LOAD;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        res_valid   = 1'b0;
        case (r_state)
            S_LOAD:   if (w_load_last) w_state_nxt = S_SEARCH;
            S_SEARCH: if (w_term) w_state_nxt = S_DONE;
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) w_state_nxt = S_LOAD;
            end
            default:  w_state_nxt = S_LOAD;
        endcase
    end

    // Current-block store carries no control meaning, so it needs no reset
    always_ff @(posedge clk) begin
        if (w_accept) r_cur[r_load_row] <= cur_row;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live       <= 1'b0;
            r_load_row   <= '0;
            r_et_en      <= 1'b0;
            r_thresh     <= '0;
            r_px         <= '0;
            r_py         <= '0;
            r_prow       <= '0;
            r_all_issued <= 1'b0;
            r_ret_valid  <= 1'b0;
            r_ret_x      <= '0;
            r_ret_y      <= '0;
            r_ret_row    <= '0;
            r_acc        <= '0;
            r_best_sad   <= '1;
            r_best_x     <= '0;
            r_best_y     <= '0;
            r_cand_cnt   <= '0;
            mv_x         <= '0;
            mv_y         <= '0;
            min_sad      <= '0;
            cand_cnt     <= '0;
        end else begin
            r_live      <= 1'b1;
            r_ret_valid <= w_iss_en;
            r_ret_x     <= w_iss_x;
            r_ret_y     <= w_iss_y;
            r_ret_row   <= w_iss_row;

            if (w_accept) begin
                if (w_load_last) begin
                    r_load_row   <= '0;
                    r_et_en      <= early_term_en;
                    r_thresh     <= sad_thresh;
                    r_px         <= '0;
                    r_py         <= '0;
                    r_prow       <= '0;
                    r_all_issued <= 1'b0;
                    r_best_sad   <= '1;
                    r_best_x     <= '0;
                    r_best_y     <= '0;
                    r_cand_cnt   <= '0;
                end else begin
                    r_load_row <= r_load_row + RW'(1);
                end
            end

            if (w_iss_en) begin
                if (w_iss_row == '0) r_cand_cnt <= r_cand_cnt + 16'd1;
                if (w_iss_row == c_ROW_LAST) begin
                    r_prow <= '0;
                    if (w_iss_x == c_LAST) begin
                        r_px <= '0;
                        if (w_iss_y == c_LAST) r_all_issued <= 1'b1;
                        else                   r_py <= w_iss_y + CW'(1);
                    end else begin
                        r_px <= w_iss_x + CW'(1);
                        r_py <= w_iss_y;
                    end
                end else begin
                    r_prow <= w_iss_row + RW'(1);
                    r_px   <= w_iss_x;
                    r_py   <= w_iss_y;
                end
            end

            if (w_ret_search) r_acc <= w_acc_new;

            if (w_complete) begin
                r_best_sad <= w_acc_new;
                r_best_x   <= r_ret_x;
                r_best_y   <= r_ret_y;
            end

            if (w_term) begin
                mv_x     <= MVW'(w_best_x_nxt) - MVW'(SEARCH_RANGE);
                mv_y     <= MVW'(w_best_y_nxt) - MVW'(SEARCH_RANGE);
                min_sad  <= w_best_sad_nxt;
                cand_cnt <= r_cand_cnt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_me_fullsearch.sv
`default_nettype none
// ============================================================================
// Module   : tb_me_fullsearch
// Purpose  : Directed self-checking bench for me_fullsearch (4x4, range 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_me_fullsearch;

    localparam int c_B   = 4;
    localparam int c_R   = 8;
    localparam int c_P   = 8;
    localparam int c_W   = c_B + 2*c_R;
    localparam int c_CW  = $clog2(c_W);
    localparam int c_MVW = $clog2(c_R+1) + 1;
    localparam int c_SW  = c_P + 2*$clog2(c_B);

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   cur_valid = 1'b0;
    logic                   cur_ready;
    logic [c_B*c_P-1:0]     cur_row = '0;
    logic                   early_term_en = 1'b0;
    logic [c_SW-1:0]        sad_thresh = '0;
    logic                   ref_rd_en;
    logic [c_CW-1:0]        ref_rd_x, ref_rd_y;
    logic [c_B*c_P-1:0]     ref_rd_data = '0;
    logic                   res_valid;
    logic                   res_ready = 1'b0;
    logic signed [c_MVW-1:0] mv_x, mv_y;
    logic [c_SW-1:0]        min_sad;
    logic [15:0]            cand_cnt;

    logic [7:0] win [c_W][c_W];
    logic [7:0] cur [c_B][c_B];

    int n_cmp = 0;
    int n_err = 0;
    int last_x, last_y;

    me_fullsearch #(.BLK_DIM(c_B), .SEARCH_RANGE(c_R), .PIX_W(c_P)) dut (
        .clk(clk), .rst(rst),
        .cur_valid(cur_valid), .cur_ready(cur_ready), .cur_row(cur_row),
        .early_term_en(early_term_en), .sad_thresh(sad_thresh),
        .ref_rd_en(ref_rd_en), .ref_rd_x(ref_rd_x), .ref_rd_y(ref_rd_y),
        .ref_rd_data(ref_rd_data),
        .res_valid(res_valid), .res_ready(res_ready),
        .mv_x(mv_x), .mv_y(mv_y), .min_sad(min_sad), .cand_cnt(cand_cnt)
    );

    always #5 clk = ~clk;

    // Search-window RAM: one-cycle read latency
    always @(posedge clk) begin
        if (ref_rd_en) begin
            for (int i = 0; i < c_B; i++)
                ref_rd_data[i*c_P +: c_P] <= win[ref_rd_y][int'(ref_rd_x) + i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic fill_flat(input logic [7:0] wv, input logic [7:0] cv);
        for (int y = 0; y < c_W; y++)
            for (int x = 0; x < c_W; x++) win[y][x] = wv;
        for (int r = 0; r < c_B; r++)
            for (int i = 0; i < c_B; i++) cur[r][i] = cv;
    endtask

    task automatic fill_unique();
        int unsigned seed;
        seed = 32'h1234_5678;
        for (int y = 0; y < c_W; y++)
            for (int x = 0; x < c_W; x++) begin
                seed = seed * 32'd1103515245 + 32'd12345;
                win[y][x] = seed[23:16];
            end
        for (int r = 0; r < c_B; r++)
            for (int i = 0; i < c_B; i++) cur[r][i] = win[5+r][11+i];
    endtask

    task automatic load_block(input logic et, input logic [c_SW-1:0] th);
        int tmo;
        for (int r = 0; r < c_B; r++) begin
            @(negedge clk);
            tmo = 0;
            while (!cur_ready && tmo < 20) begin
                @(negedge clk);
                tmo++;
            end
            if (!cur_ready) chk("load_ready_timeout", 32'(cur_ready), 32'd1);
            cur_valid     = 1'b1;
            early_term_en = et;
            sad_thresh    = th;
            for (int i = 0; i < c_B; i++) cur_row[i*c_P +: c_P] = cur[r][i];
        end
        @(negedge clk);
        cur_valid = 1'b0;
    endtask

    // Starts in the first SEARCH cycle; counts cycles and read strobes until result
    task automatic run_wait(output int nrd, output int ncyc);
        nrd  = 0;
        ncyc = 0;
        while (!res_valid && ncyc < 5000) begin
            if (ref_rd_en) begin
                nrd++;
                last_x = int'(ref_rd_x);
                last_y = int'(ref_rd_y);
            end
            ncyc++;
            @(negedge clk);
        end
        chk("result_timeout", 32'(res_valid), 32'd1);
    endtask

    task automatic accept();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("hs_res_valid_low", 32'(res_valid), 32'd0);
        chk("hs_cur_ready_high", 32'(cur_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_cur_ready"}, 32'(cur_ready), 32'd0);
        chk({pfx, "_ref_rd_en"}, 32'(ref_rd_en), 32'd0);
        chk({pfx, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({pfx, "_mv_x"}, 32'(mv_x), 32'd0);
        chk({pfx, "_mv_y"}, 32'(mv_y), 32'd0);
        chk({pfx, "_min_sad"}, 32'(min_sad), 32'd0);
        chk({pfx, "_cand_cnt"}, 32'(cand_cnt), 32'd0);
    endtask

    initial begin
        int nrd, ncyc, extra_rd;

        // Reset state
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_release_ready", 32'(cur_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_edge", 32'(cur_ready), 32'd1);

        // Flat match: every candidate after the first aborts at row 0
        fill_flat(8'd10, 8'd10);
        load_block(1'b0, '0);
        run_wait(nrd, ncyc);
        chk("flat_mv_x", 32'(mv_x), -32'sd8);
        chk("flat_mv_y", 32'(mv_y), -32'sd8);
        chk("flat_sad", 32'(min_sad), 32'd0);
        chk("flat_cnt", 32'(cand_cnt), 32'd289);
        chk("flat_reads", 32'(nrd), 32'd292);
        chk("flat_cycles", 32'(ncyc), 32'd293);
        accept();

        // Unique match at window origin (11,5)
        fill_unique();
        load_block(1'b0, '0);
        chk("hold_mv_x_in_search", 32'(mv_x), -32'sd8);
        run_wait(nrd, ncyc);
        chk("uniq_mv_x", 32'(mv_x), 32'sd3);
        chk("uniq_mv_y", 32'(mv_y), -32'sd3);
        chk("uniq_sad", 32'(min_sad), 32'd0);
        chk("uniq_cnt", 32'(cand_cnt), 32'd289);
        accept();

        // Threshold stop on the matching candidate (index 96)
        load_block(1'b1, '0);
        run_wait(nrd, ncyc);
        chk("thr_mv_x", 32'(mv_x), 32'sd3);
        chk("thr_mv_y", 32'(mv_y), -32'sd3);
        chk("thr_sad", 32'(min_sad), 32'd0);
        chk("thr_cnt", 32'(cand_cnt), 32'd97);
        chk("thr_last_rd_x", 32'(last_x), 32'd11);
        chk("thr_last_rd_y", 32'(last_y), 32'd8);
        extra_rd = 0;
        for (int k = 0; k < 5; k++) begin
            if (ref_rd_en) extra_rd++;
            @(negedge clk);
        end
        chk("thr_no_reads_done", 32'(extra_rd), 32'd0);
        accept();

        // Max SAD: no wrap, every later candidate drops on its last row
        fill_flat(8'd0, 8'd255);
        load_block(1'b0, '0);
        run_wait(nrd, ncyc);
        chk("max_sad", 32'(min_sad), 32'd4080);
        chk("max_mv_x", 32'(mv_x), -32'sd8);
        chk("max_mv_y", 32'(mv_y), -32'sd8);
        chk("max_cnt", 32'(cand_cnt), 32'd289);
        chk("max_reads", 32'(nrd), 32'd1156);
        chk("max_cycles", 32'(ncyc), 32'd1157);

        // Backpressure: result held stable for 20 cycles
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("bp_res_valid", 32'(res_valid), 32'd1);
            chk("bp_mv_x", 32'(mv_x), -32'sd8);
            chk("bp_min_sad", 32'(min_sad), 32'd4080);
            chk("bp_cur_ready", 32'(cur_ready), 32'd0);
        end
        accept();
        chk("hold_sad_in_load", 32'(min_sad), 32'd4080);

        // Reset pulse at the 50th SEARCH cycle
        fill_unique();
        load_block(1'b0, '0);
        repeat (49) @(negedge clk);
        rst = 1'b1;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        load_block(1'b0, '0);
        run_wait(nrd, ncyc);
        chk("post_rst_mv_x", 32'(mv_x), 32'sd3);
        chk("post_rst_mv_y", 32'(mv_y), -32'sd3);
        chk("post_rst_sad", 32'(min_sad), 32'd0);
        chk("post_rst_cnt", 32'(cand_cnt), 32'd289);
        accept();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
